alu_muldiv_sequencer: RTL and testbench

//  Multi-cycle unsigned multiply/divide engine that acts as the initiator on the ALU command interface.

---
 rtl/alu_muldiv_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer
//   Multi-cycle unsigned multiply / divide engine. It runs its arithmetic
//   through an attached combinational ALU: each cycle it drives one command
//   and one operand pair, and it uses the ALU's out/overflow in that same
//   cycle. MUL is shift-and-add and takes W cycles. DIV is restoring and
//   takes 2 cycles per bit: compare, then subtract.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         request handshake; req_op 0=MUL 1=DIV
//   req_a, req_b                multiplicand/dividend, multiplier/divisor
//   rsp_valid/rsp_ready         response handshake; response held until accepted
//   rsp_result, rsp_remainder   product (mod 2^W) or quotient / remainder
//   rsp_flag                    MUL overflow or DIV divide-by-zero
//   alu_a, alu_b, alu_command   ALU command interface (4'hF = idle)
//   alu_out, alu_overflow       ALU result and carry/compare, same cycle

module alu_muldiv_sequencer #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [BUS_WIDTH-1:0] req_a,
  input  logic [BUS_WIDTH-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_result,
  output logic [BUS_WIDTH-1:0] rsp_remainder,
  output logic                 rsp_flag,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic [3:0]           alu_command,
  input  logic [BUS_WIDTH-1:0] alu_out,
  input  logic                 alu_overflow
);

  localparam int unsigned   CW       = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_WIDTH - 1);
  localparam logic [3:0]    CMD_ADD  = 4'h0;
  localparam logic [3:0]    CMD_SUB  = 4'h1;
  localparam logic [3:0]    CMD_LT   = 4'h9;
  localparam logic [3:0]    CMD_IDLE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BUS_WIDTH-1:0] opa_q, opa_d;   // MUL: shifting multiplicand; DIV: dividend
  logic [BUS_WIDTH-1:0] opb_q, opb_d;   // MUL: multiplier; DIV: divisor
  logic [BUS_WIDTH-1:0] acc_q, acc_d;   // MUL: product; DIV: quotient (shifted in MSB first)
  logic [BUS_WIDTH-1:0] rem_q, rem_d;
  logic                 flag_q, flag_d;
  logic                 lost_q, lost_d; // a multiplicand bit has been shifted out
  logic                 qbit_q, qbit_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Partial remainder shifted left by one, with the next dividend bit brought
  // in. hi is the bit that falls off the top. When hi=1 the true value is
  // >= 2^W > b, so the bit is taken regardless of the compare result, and the
  // subtraction mod 2^W still produces the right remainder.
  logic                 div_hi;
  logic [BUS_WIDTH-1:0] div_r;

  always_comb begin
    state_d       = state_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    acc_d         = acc_q;
    rem_d         = rem_q;
    flag_d        = flag_q;
    lost_d        = lost_q;
    qbit_d        = qbit_q;
    cnt_d         = cnt_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_result    = '0;
    rsp_remainder = '0;
    rsp_flag      = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_command   = CMD_IDLE;
    div_hi        = rem_q[BUS_WIDTH-1];
    div_r         = {rem_q[BUS_WIDTH-2:0], opa_q[cnt_q]};

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          opa_d  = req_a;
          opb_d  = req_b;
          acc_d  = '0;
          rem_d  = '0;
          flag_d = 1'b0;
          lost_d = 1'b0;
          if (!req_op) begin
            cnt_d   = '0;
            state_d = S_MUL;
          end else if (req_b == '0) begin
            acc_d   = '1;
            rem_d   = req_a;
            flag_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = CNT_LAST;
            state_d = S_DIV_CMP;
          end
        end
      end

      S_MUL: begin
        alu_command = CMD_ADD;
        alu_a       = acc_q;
        alu_b       = opa_q;
        if (opb_q[cnt_q]) begin
          acc_d  = alu_out;
          flag_d = flag_q | alu_overflow | lost_q;
        end
        lost_d = lost_q | opa_q[BUS_WIDTH-1];
        opa_d  = opa_q << 1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                   cnt_d   = cnt_q + CW'(1);
      end

      S_DIV_CMP: begin
        alu_command = CMD_LT;
        alu_a       = div_r;
        alu_b       = opb_q;
        qbit_d      = div_hi | ~alu_overflow;
        state_d     = S_DIV_SUB;
      end

      S_DIV_SUB: begin
        alu_command = CMD_SUB;
        alu_a       = div_r;
        alu_b       = opb_q;
        rem_d       = qbit_q ? alu_out : div_r;
        acc_d       = {acc_q[BUS_WIDTH-2:0], qbit_q};
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = S_DIV_CMP;
        end
      end

      S_DONE: begin
        rsp_valid     = 1'b1;
        rsp_result    = acc_q;
        rsp_remainder = rem_q;
        rsp_flag      = flag_q;
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      flag_q  <= 1'b0;
      lost_q  <= 1'b0;
      qbit_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      flag_q  <= flag_d;
      lost_q  <= lost_d;
      qbit_q  <= qbit_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Testbench for alu_muldiv_sequencer. It provides a behavioural ALU on the
// command interface, then runs a table of directed vectors, handshake and
// reset corner sequences, and randomized operations. Results are checked
// against plain-arithmetic expectations.

module tb_alu_muldiv_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_op;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result, rsp_remainder;
  logic         rsp_flag;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [3:0]   alu_command;
  logic         alu_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_sequencer #(.BUS_WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_remainder(rsp_remainder),
    .rsp_flag     (rsp_flag),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_command  (alu_command),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow)
  );

  // Behavioural ALU: add with carry out, subtract, unsigned less-than.
  always_comb begin
    alu_out      = '0;
    alu_overflow = 1'b0;
    case (alu_command)
      4'h0: {alu_overflow, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1: {alu_overflow, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      4'h9: alu_overflow = (alu_a < alu_b);
      default: ;
    endcase
  end

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] rem;
    logic       flag;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [7:0] rem;
    logic       flag;
    int         lat;
  } exp_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_model(input logic op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   p;
    if (!op) begin
      p      = int'(a) * int'(b);
      e.res  = 8'(p % 256);
      e.rem  = 8'h00;
      e.flag = (p >= 256);
      e.lat  = W + 1;
    end else if (b == 8'h00) begin
      e.res  = 8'hFF;
      e.rem  = a;
      e.flag = 1'b1;
      e.lat  = 1;
    end else begin
      e.res  = 8'(int'(a) / int'(b));
      e.rem  = 8'(int'(a) % int'(b));
      e.flag = 1'b0;
      e.lat  = 2 * W + 1;
    end
    return e;
  endfunction

  // Issue one request, measure request-to-response latency, check the result,
  // optionally hold rsp_ready low (poking a new request meanwhile), then
  // complete the response handshake.
  task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b,
                        input exp_t e, input int hold, input bit poke, input string tag);
    int n;
    bit saw_cmd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    // Scramble the request inputs after acceptance; the engine must use its latched copy.
    req_valid = 1'b0;
    req_op    = 1'($urandom);
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    n         = 1;
    saw_cmd   = 1'b0;
    while (!rsp_valid && n < 100) begin
      if (alu_command !== 4'hF) saw_cmd = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, e.lat);
    check({tag, ".alu_used"}, saw_cmd, (op && b == 8'h00) ? 0 : 1);
    check({tag, ".result"}, rsp_result, e.res);
    check({tag, ".remainder"}, rsp_remainder, e.rem);
    check({tag, ".flag"}, rsp_flag, e.flag);
    check({tag, ".done_alu_cmd"}, alu_command, 4'hF);
    check({tag, ".done_req_ready"}, req_ready, 0);
    if (poke) begin
      req_valid = 1'b1;
      req_op    = 1'b0;
      req_a     = 8'h05;
      req_b     = 8'h05;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, rsp_valid, 1);
      check({tag, ".hold_result"}, rsp_result, e.res);
      check({tag, ".hold_remainder"}, rsp_remainder, e.rem);
      check({tag, ".hold_flag"}, rsp_flag, e.flag);
      check({tag, ".hold_req_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, ".post_rsp_valid"}, rsp_valid, 0);
    check({tag, ".post_req_ready"}, req_ready, 1);
  endtask

  vec_t vecs[8];

  initial begin
    exp_t e;
    logic op;
    logic [7:0] a, b;

    vecs[0] = '{1'b0, 8'd13,  8'd11,  8'h8F, 8'd0,  1'b0, 9};
    vecs[1] = '{1'b0, 8'd20,  8'd13,  8'h04, 8'd0,  1'b1, 9};
    vecs[2] = '{1'b0, 8'hFF,  8'h01,  8'hFF, 8'd0,  1'b0, 9};
    vecs[3] = '{1'b0, 8'h80,  8'h02,  8'h00, 8'd0,  1'b1, 9};
    vecs[4] = '{1'b1, 8'd200, 8'd7,   8'd28, 8'd4,  1'b0, 17};
    vecs[5] = '{1'b1, 8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 17};
    vecs[6] = '{1'b1, 8'd255, 8'd200, 8'd1,  8'd55, 1'b0, 17};
    vecs[7] = '{1'b1, 8'd9,   8'd0,   8'hFF, 8'd9,  1'b1, 1};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset.req_ready", req_ready, 1);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rsp_result", rsp_result, 0);
    check("reset.rsp_remainder", rsp_remainder, 0);
    check("reset.rsp_flag", rsp_flag, 0);
    check("reset.alu_a", alu_a, 0);
    check("reset.alu_b", alu_b, 0);
    check("reset.alu_command", alu_command, 4'hF);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      e.res  = vecs[i].res;
      e.rem  = vecs[i].rem;
      e.flag = vecs[i].flag;
      e.lat  = vecs[i].lat;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Response back-pressure with a competing request present.
    e.res = 8'd28; e.rem = 8'd4; e.flag = 1'b0; e.lat = 17;
    run_op(1'b1, 8'd200, 8'd7, e, 5, 1'b1, "hold");

    // Reset in the middle of a divide.
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_a     = 8'd200;
    req_b     = 8'd7;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("midreset.busy_req_ready", req_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midreset.rsp_valid", rsp_valid, 0);
    check("midreset.req_ready", req_ready, 1);
    check("midreset.alu_command", alu_command, 4'hF);
    reset = 1'b0;
    e = ref_model(1'b0, 8'd3, 8'd3);
    check("midreset.model_3x3", e.res, 9);
    run_op(1'b0, 8'd3, 8'd3, e, 0, 1'b0, "after_reset");

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 60; i++) begin
      op = 1'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      e  = ref_model(op, a, b);
      run_op(op, a, b, e, int'($urandom_range(0, 2)), 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
